// File: rtl/i2s_rx_array.sv
// i2s_rx_array: N-channel I2S receiver sharing one generated sck/ws pair.
// Left-slot samples from all channels are captured together and handed out
// as one wide word through a single-entry valid/ready holding register.
// Build option: define I2S_RX_ARRAY_OVERRUN_CNT_EN to implement the
// saturating overrun counter; otherwise overrun_cnt is tied to zero.
module i2s_rx_array #(
  parameter int NCH      = 4,
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int PERIOD_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PERIOD_W-1:0]      sck_period,
  input  logic [NCH-1:0]           ch_en,
  input  logic [NCH-1:0]           sd,
  output logic                     sck,
  output logic                     ws,
  output logic [NCH*SAMPLE_W-1:0]  dout,
  output logic                     dout_vld,
  input  logic                     dout_rdy,
  output logic [7:0]               overrun_cnt
);

  localparam int BIT_W = $clog2(2*SLOT_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2*SLOT_W-1);
  localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] BIT_SMP  = BIT_W'(SAMPLE_W);

  logic [PERIOD_W-1:0]     div;
  logic [PERIOD_W-1:0]     h_lim;
  logic                    h_lim_vld;
  logic [PERIOD_W-1:0]     period_eff;
  logic [PERIOD_W-1:0]     lim;
  logic                    tc;
  logic                    rise_ev;
  logic                    fall_ev;
  logic [BIT_W-1:0]        bit_cnt;
  logic [BIT_W-1:0]        bit_cnt_nxt;
  logic                    cap_ev;
  logic                    frame_done;
  logic                    overrun;
  logic                    load;
  logic [NCH*SAMPLE_W-1:0] shreg;
  logic [NCH*SAMPLE_W-1:0] shift_nxt;
  logic [NCH*SAMPLE_W-1:0] frame_word;

  // Until the first terminal count has latched a half-period, the live
  // setting is used so the first rise lands H cycles after reset.
  assign period_eff = (sck_period == '0) ? PERIOD_W'(1) : sck_period;
  assign lim        = h_lim_vld ? h_lim : period_eff;
  assign tc         = (div == lim - PERIOD_W'(1));
  assign rise_ev    = tc & ~sck;
  assign fall_ev    = tc & sck;

  assign bit_cnt_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
  assign cap_ev      = rise_ev && (bit_cnt != '0) && (bit_cnt <= BIT_SMP);
  assign frame_done  = rise_ev && (bit_cnt == BIT_SMP);
  assign overrun     = frame_done & dout_vld & ~dout_rdy;
  assign load        = frame_done & ~overrun;

  // Half-period divider; the period setting is re-sampled only at terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= '0;
      sck       <= 1'b0;
      h_lim     <= '0;
      h_lim_vld <= 1'b0;
    end else if (tc) begin
      div       <= '0;
      sck       <= ~sck;
      h_lim     <= period_eff;
      h_lim_vld <= 1'b1;
    end else begin
      div <= div + PERIOD_W'(1);
    end
  end

  // Bit position within the frame and word select, both advanced on sck fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      ws      <= 1'b0;
    end else if (fall_ev) begin
      bit_cnt <= bit_cnt_nxt;
      ws      <= (bit_cnt_nxt >= BIT_SLOT);
    end
  end

  // Next shift value per lane and the masked word presented at frame completion
  always_comb begin
    shift_nxt  = '0;
    frame_word = '0;
    for (int k = 0; k < NCH; k++) begin
      shift_nxt[k*SAMPLE_W +: SAMPLE_W]  = {shreg[k*SAMPLE_W +: SAMPLE_W-1], sd[k]};
      frame_word[k*SAMPLE_W +: SAMPLE_W] = ch_en[k] ? shift_nxt[k*SAMPLE_W +: SAMPLE_W]
                                                    : {SAMPLE_W{1'b0}};
    end
  end

  // MSB-first capture of the left-slot bits on sck rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (cap_ev) begin
      shreg <= shift_nxt;
    end
  end

  // Holding register: an overrun drops the new frame and keeps the old one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else if (load) begin
      dout     <= frame_word;
      dout_vld <= 1'b1;
    end else if (dout_vld && dout_rdy) begin
      dout_vld <= 1'b0;
    end
  end

`ifdef I2S_RX_ARRAY_OVERRUN_CNT_EN
  // Saturating count of dropped frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= 8'd0;
    end else if (overrun && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule

// File: doc/i2s_rx_array.md
# i2s_rx_array

Parametrised N-channel I2S capture front-end and the successor to the per-microphone receiver instances plus valid/ready merge in the ANC chip top. One shared bit clock and word select drive all channels (error, reference, audio and step-size microphones, plus any future additions). Left-slot samples from every enabled channel are captured in lock-step and presented as one wide word under a single valid/ready handshake. Overrun detection is optional.

## Interface
- NCH, 4, number of serial data inputs
- SAMPLE_W, 16, captured bits per channel; must be ≤ SLOT_W-1
- SLOT_W, 32, sck cycles per half-frame (per ws level)
- PERIOD_W, 8, width of sck_period
- clk  input  1  core clock
- rst_n  input  1  reset, asynchronous, active-low
- sck_period  input  PERIOD_W  sck half-period in clk cycles; 0 is treated as 1
- ch_en  input  NCH  per-channel enable; a disabled lane outputs zero
- sd  input  NCH  serial data, one bit per channel
- sck  output  1  I2S bit clock
- ws  output  1  I2S word select; 0 = left slot
- dout  output  NCH*SAMPLE_W  signed samples; channel k occupies bits [k*SAMPLE_W +: SAMPLE_W]
- dout_vld  output  1  holding register full
- dout_rdy  input  1  consumer accepts
- overrun_cnt  output  8  saturating count of dropped frames

## Operation
- **Divider**
  - H = max(sck_period, 1).
  - A div counter counts 0..H-1. At terminal count, sck toggles and div restarts.
  - sck_period is sampled only at terminal count, so a mid-phase change takes effect at the next half-period.
- **Bit counter**
  - bit_cnt counts 0..2*SLOT_W-1.
  - Each falling sck toggle increments it, wrapping to 0.
  - ws = (bit_cnt ≥ SLOT_W), registered so it updates with the falling edge.
- **Capture**
  - Sampling point is the clk cycle in which sck toggles 0→1 (rise event).
  - On a rise event with bit_cnt in 1..SAMPLE_W, every channel shifts sd[k] into its shift register, MSB first.
  - This is the standard one-bit I2S delay after the ws edge.
  - The right slot is ignored.
- **Frame complete**
  - Occurs on the rise event with bit_cnt == SAMPLE_W.
  - Holding register load: shift register if ch_en[k]=1, else 0. ch_en is sampled at that cycle.
- **Handshake**
  - dout_vld sets on load.
  - dout_vld clears when dout_vld && dout_rdy and no load occurs in the same cycle.
  - dout is stable while dout_vld=1 and not accepted.
- **Simultaneous accept and frame complete**
  - The new frame loads and dout_vld stays 1.
  - This is not an overrun.
- **Overrun**
  - Condition: frame complete while dout_vld=1 and dout_rdy=0.
  - The new frame is dropped and the old dout is kept.
  - overrun_cnt increments, saturating at 255.
- **Reset values (any time, including mid-frame)**
  - sck=0, ws=0, dout=0, dout_vld=0, overrun_cnt=0, div=0, bit_cnt=0, shift registers 0.
  - Capture resumes from bit_cnt 0. A partial frame is never emitted.

## Timing
- sck period = 2H clk cycles.
- Frame = 2*SLOT_W*2H clk cycles; 512 for H=4, SLOT_W=32.
- First rise event: H clk cycles after reset release.
- dout_vld asserts the clk cycle after the frame-complete rise event.
- dout is registered; there are no combinational paths from sd to dout or from dout_rdy to dout_vld.
- Throughput: one frame per frame period. The consumer has until the next frame-complete event to accept.

## Configuration
- **I2S_RX_ARRAY_OVERRUN_CNT_EN**
  - Defined: the overrun counter is implemented as described above.
  - Undefined: the counter logic is removed and overrun_cnt is tied to 0.
- The drop-new/keep-old overrun policy is identical in both builds.

## Test plan
All scenarios use NCH=4, SAMPLE_W=16, SLOT_W=32, dout_rdy=1 unless stated otherwise.

- **Basic capture**
  - Stimulus: sck_period=4; drive left-slot words ch0..3 = 16'hA5C3, 16'h8001, 16'h7FFF, 16'h0000.
  - Response: sck period is 8 clk; one dout_vld pulse per 512 clk; dout = {16'h0000, 16'h7FFF, 16'h8001, 16'hA5C3}.
- **Channel disable**
  - Stimulus: as above, with ch_en=4'b1011.
  - Response: dout[47:32]=0; other lanes unchanged.
- **Overrun**
  - Stimulus: hold dout_rdy=0 across 2 frames (second frame ch0 = 16'h1234), then raise dout_rdy.
  - Response: overrun_cnt=1; dout still holds the first frame; dout_vld drops one cycle after acceptance.
  - With the macro undefined, overrun_cnt=0.
- **Simultaneous accept/load**
  - Stimulus: pulse dout_rdy exactly in the frame-complete cycle.
  - Response: new frame loaded; dout_vld stays 1; overrun_cnt unchanged.
- **Divider boundaries**
  - Stimulus: sck_period=0, then sck_period=1.
  - Response: sck toggles every clk in both cases; frame = 128 clk.
  - Changing sck_period from 1 to 3 mid-phase gives exactly one more 1-cycle half-period, then 3-cycle half-periods.
- **Reset mid-frame**
  - Stimulus: assert rst_n at bit_cnt=10 of the left slot.
  - Response: all outputs return to their reset values immediately; the first dout_vld after release comes from a fully captured new frame.
